// File: rtl/sar_ota_ctrl.sv
// Successive-approximation sequencer that turns the digOta comparator into a WIDTH-bit ADC.
// Optional result trim is enabled by defining SAR_OFFSET_TRIM_EN (adds the offset_in port).
module sar_ota_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_in,
  output logic             sample_en,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [2:0]       state_dbg
`ifdef SAR_OFFSET_TRIM_EN
  ,
  input  logic [WIDTH-1:0] offset_in
`endif
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(WIDTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SAMPLE = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] DECIDE = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             cmp_meta;
  logic             cmp_s;

  logic [WIDTH-1:0] trial_bit;
  logic [WIDTH-1:0] kept_code;
  logic [WIDTH-1:0] next_code;
  logic [WIDTH-1:0] final_code;

`ifdef SAR_OFFSET_TRIM_EN
  logic [WIDTH-1:0]        offset_q;
  logic signed [WIDTH+1:0] trim_sum;
`endif

  // Result handshake: result/result_valid are held in DONE until result_ready is
  // seen high at a clock edge; that edge drops result_valid and returns to IDLE.
  assign sample_en    = (state == SAMPLE);
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);
  assign state_dbg    = state;

  always_comb begin
    trial_bit = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
    kept_code = cmp_s ? dac_code : (dac_code & ~trial_bit);
    next_code = (idx != '0) ? (kept_code | (trial_bit >> 1)) : kept_code;
  end

`ifdef SAR_OFFSET_TRIM_EN
  // Two guard bits keep raw + signed offset exact before clamping to the code range.
  always_comb begin
    trim_sum = $signed({2'b00, kept_code}) + $signed({{2{offset_q[WIDTH-1]}}, offset_q});
    if (trim_sum[WIDTH+1]) begin
      final_code = '0;
    end else if (trim_sum[WIDTH]) begin
      final_code = '1;
    end else begin
      final_code = trim_sum[WIDTH-1:0];
    end
  end
`else
  assign final_code = kept_code;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_meta <= 1'b0;
      cmp_s    <= 1'b0;
    end else begin
      cmp_meta <= cmp_in;
      cmp_s    <= cmp_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      dac_code <= '0;
      result   <= '0;
`ifdef SAR_OFFSET_TRIM_EN
      offset_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SAMPLE;
            cnt      <= CNT_W'(SAMPLE_CYCLES - 1);
            idx      <= IDX_W'(WIDTH - 1);
            dac_code <= '0;
`ifdef SAR_OFFSET_TRIM_EN
            offset_q <= offset_in;
`endif
          end
        end
        SAMPLE: begin
          if (cnt == '0) begin
            state    <= SETTLE;
            cnt      <= CNT_W'(SETTLE_CYCLES - 1);
            dac_code <= {1'b1, {(WIDTH-1){1'b0}}};
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state <= DECIDE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DECIDE: begin
          dac_code <= next_code;
          if (idx != '0) begin
            state <= SETTLE;
            cnt   <= CNT_W'(SETTLE_CYCLES - 1);
            idx   <= idx - IDX_W'(1);
          end else begin
            state  <= DONE;
            result <= final_code;
          end
        end
        DONE: begin
          if (result_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_ota_ctrl.sv
// Self-checking bench for sar_ota_ctrl: an ideal mid-code comparator closes the loop
// and a timeline model predicts every output cycle by cycle.
module tb_sar_ota_ctrl;

  localparam int W    = 8;
  localparam int S    = 4;
  localparam int T    = 3;
  localparam int CONV = S + W * (T + 1);

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         start;
  logic         cmp_in;
  logic         sample_en;
  logic [W-1:0] dac_code;
  logic         busy;
  logic [W-1:0] result;
  logic         result_valid;
  logic         result_ready;
  logic [2:0]   state_dbg;
`ifdef SAR_OFFSET_TRIM_EN
  logic [W-1:0] offset_in;
`endif

  sar_ota_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cmp_in       (cmp_in),
    .sample_en    (sample_en),
    .dac_code     (dac_code),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .state_dbg    (state_dbg)
`ifdef SAR_OFFSET_TRIM_EN
    ,
    .offset_in    (offset_in)
`endif
  );

  // Analog side: Vip sits at vin + 1/2 LSB, so the comparator reads vin >= dac_code.
  // With glitch_en the comparator lies for the whole cycle after every DAC change.
  logic [8:0]   vin;
  logic         glitch_en;
  logic [W-1:0] dac_prev;
  logic         cmp_ideal;
  assign cmp_ideal = (vin >= {1'b0, dac_code});
  assign cmp_in    = (glitch_en && (dac_code != dac_prev)) ? ~cmp_ideal : cmp_ideal;
  always @(posedge clk) dac_prev <= dac_code;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a conversion is a timeline of S sample cycles followed by
  // W bit slots of T+1 cycles; the code shown in each slot follows from the answer.
  function automatic logic [W-1:0] ideal_code(input logic [8:0] v);
    return (v > 9'd255) ? 8'hFF : v[7:0];
  endfunction

  function automatic logic [W-1:0] trial_code(input logic [W-1:0] raw, input int k);
    int hi_mask;
    hi_mask = (~((1 << (W - k)) - 1)) & 255;
    return 8'((int'(raw) & hi_mask) | (128 >> k));
  endfunction

  function automatic logic [W-1:0] trim_code(input logic [W-1:0] raw, input logic [W-1:0] off);
    int s;
    s = int'(raw) + int'($signed(off));
    if (s < 0) return 8'h00;
    if (s > 255) return 8'hFF;
    return 8'(s);
  endfunction

  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  int           m_t    = 0;
  logic [W-1:0] m_raw  = '0;
  logic [W-1:0] m_off  = '0;
  logic [W-1:0] m_res  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_t    = 0;
      m_res  = '0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1;
        m_t    = 1;
        m_raw  = ideal_code(vin);
`ifdef SAR_OFFSET_TRIM_EN
        m_off  = offset_in;
`else
        m_off  = '0;
`endif
      end
    end else if (m_done) begin
      if (result_ready) begin
        m_busy = 1'b0;
        m_done = 1'b0;
      end
    end else begin
      m_t++;
      if (m_t > CONV) begin
        m_done = 1'b1;
        m_res  = trim_code(m_raw, m_off);
      end
    end
  end

  // Scoreboard compare, once per cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("sample_en", 32'(sample_en), 32'(m_busy && !m_done && (m_t <= S)));
      chk("result_valid", 32'(result_valid), 32'(m_done));
      if (m_busy && !m_done && (m_t <= S))
        chk("dac_sample", 32'(dac_code), 32'(0));
      if (m_busy && !m_done && (m_t > S))
        chk("dac_trial", 32'(dac_code), 32'(trial_code(m_raw, (m_t - S - 1) / (T + 1))));
      if (m_done) begin
        chk("result", 32'(result), 32'(m_res));
        chk("dac_final", 32'(dac_code), 32'(m_raw));
      end
    end
  end

  // Driver: one full conversion with optional glitches, backpressure and stray starts.
  logic [W-1:0] dac_hist [64];
  logic         busy_first;

  task automatic conv(input logic [8:0] v, input bit glitch, input int hold, input bit noise,
                      input bit poke, output int lat, output logic [W-1:0] res);
    @(negedge clk);
    vin       = v;
    glitch_en = glitch;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    res = '0;
    while (lat < 100 && !result_valid) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat < 64) dac_hist[lat] = dac_code;
      if (lat == 1) busy_first = busy;
      if (noise) start = result_valid ? 1'b0 : 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    if (!result_valid) begin
      chk("valid_timeout", 32'(result_valid), 32'(1));
      return;
    end
    res = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start = poke && (i == hold / 2);
    end
    @(negedge clk);
    start        = 1'b0;
    result_ready = 1'b1;
    @(posedge clk);
    #1 result_ready = 1'b0;
  endtask

  int           lat;
  logic [W-1:0] res;
  bit           seen;

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    result_ready = 1'b0;
    vin          = '0;
    glitch_en    = 1'b0;
`ifdef SAR_OFFSET_TRIM_EN
    offset_in    = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_sample_en", 32'(sample_en), 32'(0));
    chk("rst_dac", 32'(dac_code), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_valid", 32'(result_valid), 32'(0));
    chk_en = 1'b1;
    @(negedge clk) rst = 1'b0;

    // Nominal conversion and its trial sequence
    conv(9'h0A5, 1'b0, 0, 1'b0, 1'b0, lat, res);
    chk("a5_busy_first", 32'(busy_first), 32'(1));
    chk("a5_latency", 32'(lat), 32'(36));
    chk("a5_result", 32'(res), 32'hA5);
    chk("a5_trial0", 32'(dac_hist[5]), 32'h80);
    chk("a5_trial1", 32'(dac_hist[9]), 32'hC0);
    chk("a5_trial2", 32'(dac_hist[13]), 32'hA0);
    chk("a5_trial3", 32'(dac_hist[17]), 32'hB0);

    // Full-scale bounds
    conv(9'h100, 1'b0, 0, 1'b0, 1'b0, lat, res);
    chk("over_result", 32'(res), 32'hFF);
    chk("over_latency", 32'(lat), 32'(36));
    conv(9'h000, 1'b0, 0, 1'b0, 1'b0, lat, res);
    chk("zero_result", 32'(res), 32'h00);
    chk("zero_latency", 32'(lat), 32'(36));

    // Backpressure with a stray start while DONE
    conv(9'h0C3, 1'b0, 10, 1'b0, 1'b1, lat, res);
    chk("bp_result", 32'(res), 32'hC3);
    chk("bp_idle_busy", 32'(busy), 32'(0));
    chk("bp_idle_valid", 32'(result_valid), 32'(0));
    conv(9'h011, 1'b0, 0, 1'b0, 1'b0, lat, res);
    chk("bp_next_result", 32'(res), 32'h11);

    // Reset mid-conversion
    @(negedge clk);
    vin   = 9'h077;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_sample_en", 32'(sample_en), 32'(0));
    chk("abort_dac", 32'(dac_code), 32'(0));
    chk("abort_result", 32'(result), 32'(0));
    chk("abort_valid", 32'(result_valid), 32'(0));
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (result_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 32'(seen), 32'(0));
    conv(9'h03C, 1'b0, 0, 1'b0, 1'b0, lat, res);
    chk("post_abort_result", 32'(res), 32'h3C);

    // Comparator wrong during the first settle cycle of every bit
    conv(9'h05A, 1'b1, 0, 1'b0, 1'b0, lat, res);
    chk("glitch_result", 32'(res), 32'h5A);

`ifdef SAR_OFFSET_TRIM_EN
    offset_in = 8'hFD;
    conv(9'h0A5, 1'b0, 0, 1'b0, 1'b0, lat, res);
    chk("trim_a5_result", 32'(res), 32'hA2);
    chk("trim_a5_dac", 32'(dac_code), 32'hA5);
    conv(9'h001, 1'b0, 0, 1'b0, 1'b0, lat, res);
    chk("trim_low_sat", 32'(res), 32'h00);
    offset_in = 8'h05;
    conv(9'h0FE, 1'b0, 0, 1'b0, 1'b0, lat, res);
    chk("trim_high_sat", 32'(res), 32'hFF);
`endif

    // Randomized conversions checked by the per-cycle model
    for (int n = 0; n < 24; n++) begin
`ifdef SAR_OFFSET_TRIM_EN
      offset_in = 8'($urandom_range(0, 255));
`endif
      conv(9'($urandom_range(0, 256)), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lat, res);
      chk("rand_latency", 32'(lat), 32'(36));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
